seg7_scan_display: RTL and testbench

- Downstream display stage of the single-cycle CPU top. It drives the 4-digit multiplexed seven-segment outputs AN/SEGMENT.
- Latches a 16-bit value (PC, register or switch-selected debug word) on a load strobe and time-multiplexes the four hex digits at a prescaled scan rate.
- Inserts a one-cycle anti-ghosting blank at every digit change and flags completion of each full scan frame.

---
 rtl/seg7_scan_display.sv | 121 ++++++++++++
 tb/tb_seg7_scan_display.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: latches a 16-bit hex word and scans it across a 4-digit active-low
// seven-segment display with a one-cycle guard blank per digit. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_display #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel;
    logic             tick;

    logic [15:0] data_q;
    logic [3:0]  dp_q;
    logic [3:0]  blank_q;

    logic [3:0]  nib;
    logic [3:0]  lz_mask;
    logic [3:0]  an_p0;
    logic [7:0]  seg_p0;
    logic        frame_done_p0;

    logic [3:0]  an_p1;
    logic [7:0]  seg_p1;
    logic        frame_done_p1;

    // Hex digit to {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign nib  = data_q[{sel, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
    logic z3, z2, z1;
    assign z3      = (data_q[15:12] == 4'h0);
    assign z2      = (data_q[11:8]  == 4'h0);
    assign z1      = (data_q[7:4]   == 4'h0);
    assign lz_mask = {z3, z3 & z2, z3 & z2 & z1, 1'b0};
`else
    assign lz_mask = 4'b0000;
`endif

    // Stage p0: next output pattern from the current slot; the tick cycle is forced dark.
    always_comb begin
        an_p0         = 4'hF;
        seg_p0        = 8'hFF;
        frame_done_p0 = tick && (sel == 2'd3);
        if (!tick && !blank_q[sel]) begin
            an_p0 = ~(4'b0001 << sel);
            if (lz_mask[sel]) begin
                seg_p0 = {~dp_q[sel], 7'h7F};
            end else begin
                seg_p0 = {~dp_q[sel], enc(nib)};
            end
        end
    end

    // Stage p1: prescaler, digit select, latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            sel           <= 2'd0;
            data_q        <= 16'h0000;
            dp_q          <= 4'h0;
            blank_q       <= 4'h0;
            an_p1         <= 4'hF;
            seg_p1        <= 8'hFF;
            frame_done_p1 <= 1'b0;
        end else begin
            cnt           <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                sel <= sel + 2'd1;
            end
            if (load) begin
                data_q  <= data_in;
                dp_q    <= dp_in;
                blank_q <= blank_in;
            end
            an_p1         <= an_p0;
            seg_p1        <= seg_p0;
            frame_done_p1 <= frame_done_p0;
        end
    end

    assign AN         = an_p1;
    assign SEGMENT    = seg_p1;
    assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a cycle model pushes the expected outputs for
// each edge, and they are popped and compared once the edge has happened.
module tb_seg7_scan_display;

    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_display #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .AN         (AN),
        .SEGMENT    (SEGMENT),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_fd = -1;

    int          m_cnt = 0;
    int          m_sel = 0;
    logic [15:0] m_data = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  m_blank = 4'h0;

    function automatic logic [6:0] ref_enc(input logic [3:0] v);
        logic [6:0] t[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_expected();
        exp_t        e;
        bit          tick;
        bit          supp;
        logic [3:0]  nib;
        e.an  = 4'hF;
        e.seg = 8'hFF;
        e.fd  = 1'b0;
        if (!rst_n) begin
            m_cnt = 0; m_sel = 0; m_data = 16'h0; m_dp = 4'h0; m_blank = 4'h0;
        end else begin
            tick = (m_cnt == SCAN_DIV - 1);
            e.fd = tick && (m_sel == 3);
            if (!tick && !m_blank[m_sel]) begin
                e.an = ~(4'h1 << m_sel);
                nib  = 4'((m_data >> (4 * m_sel)) & 16'hF);
                supp = 1'b0;
`ifdef SEG7_LZB_EN
                supp = (m_sel == 3 && m_data[15:12] == 4'h0) ||
                       (m_sel == 2 && m_data[15:8] == 8'h0) ||
                       (m_sel == 1 && m_data[15:4] == 12'h0);
`endif
                e.seg = {~m_dp[m_sel], supp ? 7'h7F : ref_enc(nib)};
            end
            m_cnt = tick ? 0 : m_cnt + 1;
            if (tick) m_sel = (m_sel + 1) % 4;
            if (load) begin
                m_data = data_in; m_dp = dp_in; m_blank = blank_in;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        push_expected();
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check_val("sb_an", AN, e.an);
        check_val("sb_seg", SEGMENT, e.seg);
        check_val("sb_fd", frame_done, e.fd);
        if (!rst_n) begin
            last_fd = -1;
        end else if (frame_done === 1'b1) begin
            if (last_fd >= 0) check_val("fd_period", cyc - last_fd, 16);
            last_fd = cyc;
        end
    endtask

    task automatic wait_an(input string tag, input logic [3:0] an, input logic [7:0] seg);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (AN !== an && k < 20);
        check_val({tag, "_an"}, AN, an);
        check_val({tag, "_seg"}, SEGMENT, seg);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        int k;
        int bad;

        // Reset held for three edges, then release with no load.
        rst_n = 1'b0;
        repeat (3) cycle();
        check_val("rst_an", AN, 4'hF);
        check_val("rst_seg", SEGMENT, 8'hFF);
        check_val("rst_fd", frame_done, 1'b0);
        rst_n = 1'b1;
        cycle();
        check_val("rel_an", AN, 4'hE);
        check_val("rel_seg", SEGMENT, 8'hC0);
        wait_an("rel_d1", 4'hD, 8'hC0);
        wait_an("rel_d2", 4'hB, 8'hC0);
        wait_an("rel_d3", 4'h7, 8'hC0);

        // 12AF with the decimal point on digit 2.
        do_load(16'h12AF, 4'b0100, 4'b0000);
        wait_an("v_d0", 4'hE, 8'h8E);
        wait_an("v_d1", 4'hD, 8'h88);
        wait_an("v_d2", 4'hB, 8'h24);
        wait_an("v_d3", 4'h7, 8'hF9);

        // Several frames to exercise the frame_done period.
        repeat (40) cycle();

        // Load landing on a tick edge.
        do_load(16'h0000, 4'h0, 4'h0);
        k = 0;
        while (m_cnt != SCAN_DIV - 1 && k < 8) begin
            cycle();
            k++;
        end
        check_val("tick_align", m_cnt, SCAN_DIV - 1);
        do_load(16'h8888, 4'h0, 4'h0);
        check_val("tick_guard_an", AN, 4'hF);
        cycle();
        check_val("tick_load_seg", SEGMENT, 8'h80);
        check_val("tick_load_lit", (AN != 4'hF), 1'b1);

        // Per-digit blank mask.
        do_load(16'h5555, 4'h0, 4'b1010);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (AN == 4'hD || AN == 4'h7 || (AN == 4'hF && SEGMENT != 8'hFF)) bad++;
        end
        check_val("blank_dark", bad, 0);
        wait_an("b_d0", 4'hE, 8'h92);
        wait_an("b_d2", 4'hB, 8'h92);

        // Reset in the middle of slot 2.
        do_load(16'hABCD, 4'hF, 4'h0);
        k = 0;
        while (!(m_sel == 2 && m_cnt == 1) && k < 20) begin
            cycle();
            k++;
        end
        check_val("mid_align", m_sel, 2);
        rst_n = 1'b0;
        cycle();
        check_val("mid_rst_an", AN, 4'hF);
        check_val("mid_rst_seg", SEGMENT, 8'hFF);
        check_val("mid_rst_fd", frame_done, 1'b0);
        check_val("mid_rst_data", dut.data_q, 16'h0000);
        rst_n = 1'b1;
        do_load(16'h0042, 4'h0, 4'h0);
        wait_an("z_d0", 4'hE, 8'hA4);
        wait_an("z_d1", 4'hD, 8'h99);
`ifdef SEG7_LZB_EN
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (AN == 4'hB || AN == 4'h7) bad++;
        end
        check_val("lzb_dark", bad, 0);
`else
        wait_an("z_d2", 4'hB, 8'hC0);
        wait_an("z_d3", 4'h7, 8'hC0);
`endif
        repeat (8) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
